// File: rtl/round_key_assembler.sv
// round_key_assembler: packs key-expansion words into 128-bit round keys and buffers them for the cipher datapath
module round_key_assembler #(
  parameter int WORD_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          key_width,
  input  logic                word_valid,
  input  logic [WORD_W-1:0]   word_in,
  output logic                word_ready,
  output logic                rk_valid,
  output logic [4*WORD_W-1:0] rk_data,
  output logic [3:0]          rk_index,
  output logic                rk_last,
  input  logic                rk_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t state;
  logic [1:0] word_cnt;
  logic [3:0] rk_cnt;
  logic [3:0] nr;
  logic [3*WORD_W-1:0] sh;
  logic [4*WORD_W-1:0] mem [DEPTH];
  logic [3:0] idx_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic word_xfer;
  logic push;
  logic pop;
  // Handshake decode; word_ready depends on registered state only so rk_ready never reaches it
  always_comb begin
    word_ready = (state == COLLECT) && (word_cnt != 2'd3 || count < CW'(DEPTH));
    word_xfer  = word_valid && word_ready;
    push       = word_xfer && word_cnt == 2'd3;
    rk_valid   = count != '0;
    pop        = rk_valid && rk_ready;
    rk_data    = mem[rd_ptr];
    rk_index   = idx_mem[rd_ptr];
    rk_last    = rk_valid && rk_index == nr;
    busy       = state != IDLE;
  end
  // Session control, word packing and FIFO; start always wins and flushes the current session
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word_cnt <= '0;
      rk_cnt <= '0;
      nr <= '0;
      sh <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      done <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        idx_mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (start) begin
        word_cnt <= '0;
        rk_cnt <= '0;
        sh <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        err <= key_width == 2'b11;
        state <= key_width == 2'b11 ? IDLE : COLLECT;
        nr <= key_width == 2'b00 ? 4'd10 : key_width == 2'b01 ? 4'd12 : 4'd14;
      end else begin
        if (word_xfer) begin
          word_cnt <= word_cnt + 2'd1;
          sh <= {sh[2*WORD_W-1:0], word_in};
        end
        if (push) begin
          mem[wr_ptr] <= {sh, word_in};
          idx_mem[wr_ptr] <= rk_cnt;
          wr_ptr <= wr_ptr + 1'b1;
          rk_cnt <= rk_cnt + 4'd1;
          if (rk_cnt == nr) state <= DRAIN;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (state == DRAIN && count == '0) begin
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_round_key_assembler.sv
// tb_round_key_assembler: directed scoreboard bench for round_key_assembler
module tb_round_key_assembler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] key_width = 2'b00;
  logic word_valid = 1'b0;
  logic [31:0] word_in = '0;
  logic word_ready;
  logic rk_valid;
  logic [127:0] rk_data;
  logic [3:0] rk_index;
  logic rk_last;
  logic rk_ready = 1'b0;
  logic busy;
  logic done;
  logic err;

  round_key_assembler #(.WORD_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_width(key_width),
    .word_valid(word_valid), .word_in(word_in), .word_ready(word_ready),
    .rk_valid(rk_valid), .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last),
    .rk_ready(rk_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [3:0] i;
  } ent_t;
  ent_t sb[$];
  logic [31:0] grp [4];
  logic [127:0] popped [16];
  logic [31:0] wbase = '0;
  int nwords = 0;
  int npops = 0;
  int nlast = 0;
  int ndone = 0;
  int exp_nr = 0;
  int vectors = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    nwords = 0;
    npops = 0;
    nlast = 0;
    ndone = 0;
  endtask

  // One clock: drive, observe handshakes on the falling edge, return just after the rising edge
  task automatic step(input logic wv, input logic rr);
    ent_t e;
    word_valid = wv;
    rk_ready = rr;
    word_in = wbase + 32'(nwords);
    @(negedge clk);
    if (done) ndone++;
    if (rk_valid && rk_ready) begin
      chk("pop_nonempty", 128'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rk_data", rk_data, e.d);
        chk("rk_index", 128'(rk_index), 128'(e.i));
        chk("rk_last", 128'(rk_last), 128'(int'(e.i) == exp_nr));
        popped[e.i] = rk_data;
        npops++;
        if (rk_last) nlast++;
      end
    end
    if (word_valid && word_ready) begin
      grp[nwords % 4] = word_in;
      if (nwords % 4 == 3) begin
        e.d = {grp[0], grp[1], grp[2], grp[3]};
        e.i = 4'(nwords / 4);
        sb.push_back(e);
      end
      nwords++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] kw);
    start = 1'b1;
    key_width = kw;
    step(1'b0, 1'b0);
    start = 1'b0;
    clear_model();
    exp_nr = kw == 2'b00 ? 10 : kw == 2'b01 ? 12 : 14;
  endtask

  task automatic run_until_done(input logic wv, input logic rr);
    for (int i = 0; i < 300 && ndone == 0; i++) step(wv, rr);
    chk("done_within_budget", 128'(ndone > 0), 128'd1);
  endtask

  initial begin
    #3;
    chk("reset_rk_valid", 128'(rk_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_word_ready", 128'(word_ready), 128'd0);
    chk("reset_done_err", 128'({done, err}), 128'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 128-bit streaming session
    wbase = 32'h0;
    do_start(2'b00);
    chk("busy_after_start", 128'(busy), 128'd1);
    run_until_done(1'b1, 1'b1);
    chk("s128_pops", 128'(npops), 128'd11);
    chk("s128_key0", popped[0], 128'h00000000_00000001_00000002_00000003);
    chk("s128_key10", popped[10], 128'h00000028_00000029_0000002a_0000002b);
    chk("s128_last_once", 128'(nlast), 128'd1);
    chk("s128_words", 128'(nwords), 128'd44);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("s128_done_once", 128'(ndone), 128'd1);
    chk("s128_idle_ready", 128'({busy, word_ready}), 128'd0);
    // 256-bit with back-pressure until the FIFO fills
    wbase = 32'h1000;
    do_start(2'b10);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
    chk("bp_words_held", 128'(nwords), 128'd11);
    chk("bp_ready_low_full", 128'(word_ready), 128'd0);
    chk("bp_rk_valid", 128'(rk_valid), 128'd1);
    chk("bp_head_index", 128'(rk_index), 128'd0);
    // Pop while full and word_cnt==3: the push waits one cycle
    step(1'b1, 1'b1);
    chk("pp_no_push_same_cycle", 128'(nwords), 128'd11);
    chk("pp_ready_next", 128'(word_ready), 128'd1);
    run_until_done(1'b1, 1'b1);
    chk("s256_pops", 128'(npops), 128'd15);
    chk("s256_key14", popped[14], {wbase + 32'd56, wbase + 32'd57, wbase + 32'd58, wbase + 32'd59});
    chk("s256_words", 128'(nwords), 128'd60);
    chk("s256_sb_empty", 128'(sb.size()), 128'd0);
    // Illegal width
    do_start(2'b11);
    chk("ill_err", 128'(err), 128'd1);
    chk("ill_busy", 128'(busy), 128'd0);
    chk("ill_ready", 128'(word_ready), 128'd0);
    step(1'b1, 1'b1);
    chk("ill_err_one_cycle", 128'(err), 128'd0);
    chk("ill_still_idle", 128'({busy, word_ready}), 128'd0);
    chk("ill_no_words", 128'(nwords), 128'd0);
    // 192-bit session aborted after 20 words
    wbase = 32'h2000;
    do_start(2'b01);
    for (int i = 0; i < 60 && nwords < 20; i++) step(1'b1, 1'b1);
    chk("ab_words", 128'(nwords), 128'd20);
    chk("ab_old_no_done", 128'(ndone), 128'd0);
    wbase = 32'h3000;
    do_start(2'b01);
    chk("ab_flushed", 128'(rk_valid), 128'd0);
    chk("ab_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("ab_first_index", 128'(rk_index), 128'd0);
    chk("ab_first_data", rk_data, {wbase, wbase + 32'd1, wbase + 32'd2, wbase + 32'd3});
    run_until_done(1'b1, 1'b1);
    chk("ab_new_pops", 128'(npops), 128'd13);
    chk("ab_done_once", 128'(ndone), 128'd1);
    // Reset in the middle of a session
    wbase = 32'h4000;
    do_start(2'b00);
    for (int i = 0; i < 20 && nwords < 8; i++) step(1'b1, 1'b0);
    chk("rs_two_buffered", 128'(rk_valid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_clear", 128'({rk_valid, busy, word_ready}), 128'd0);
    #3 rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    chk("rs_stay_idle", 128'({rk_valid, busy, word_ready}), 128'd0);
    chk("rs_no_words", 128'(nwords), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
